// File: rtl/reference_buffer_ctrl.sv
// Read-index sequencer for the CAF reference buffer: issues multi-sweep index
// streams with wrap-around and tracks the returned samples per sweep.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for a start command with non-zero len and sweeps
//   S_RUN   | issuing indices, bounded by the outstanding limit
//   S_DRAIN | all indices issued, collecting remaining samples
//   S_DONE  | one-cycle completion pulse
module reference_buffer_ctrl #(
  parameter int BUFFER_BITS     = 8,
  parameter int LEN_BITS        = 8,
  parameter int SWEEP_BITS      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BUFFER_BITS-1:0] cfg_base,
  input  logic [LEN_BITS-1:0]    cfg_len,
  input  logic [SWEEP_BITS-1:0]  cfg_sweeps,
  input  logic [BUFFER_BITS-1:0] cfg_stride,
  output logic                   m_axis_index_tvalid,
  output logic [BUFFER_BITS-1:0] m_axis_index_tdata,
  input  logic                   m_axis_index_tready,
  input  logic                   buf_data_tvalid,
  output logic                   buf_data_tready,
  input  logic                   out_tready,
  output logic                   out_tlast,
  output logic [SWEEP_BITS-1:0]  out_sweep,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_t state, state_nx;

  logic [LEN_BITS-1:0]    len_q;
  logic [SWEEP_BITS-1:0]  sweeps_q;
  logic [BUFFER_BITS-1:0] stride_q;
  logic [BUFFER_BITS-1:0] sweep_base;
  logic [BUFFER_BITS-1:0] iss_addr;
  logic [LEN_BITS-1:0]    iss_cnt;
  logic [SWEEP_BITS-1:0]  iss_sweep;
  logic [LEN_BITS-1:0]    ret_cnt;
  logic [SWEEP_BITS-1:0]  ret_sweep;
  logic [3:0]             outstanding;
  logic [3:0]             outstanding_nx;
  logic                   tvalid_q;
  logic                   tvalid_nx;

  logic active;
  logic start_ok;
  logic hs;
  logic acc;
  logic iss_end_sweep;
  logic iss_last;
  logic ret_end_sweep;
  logic ret_last;

  assign active        = (state == S_RUN) || (state == S_DRAIN);
  assign start_ok      = start && (cfg_len != '0) && (cfg_sweeps != '0);
  assign hs            = tvalid_q && m_axis_index_tready;
  // A sample with nothing outstanding is a protocol error; it is not counted.
  assign acc           = buf_data_tvalid && buf_data_tready && (outstanding != 4'd0);
  assign iss_end_sweep = (iss_cnt == len_q - LEN_BITS'(1));
  assign iss_last      = hs && iss_end_sweep && (iss_sweep == sweeps_q - SWEEP_BITS'(1));
  assign ret_end_sweep = (ret_cnt == len_q - LEN_BITS'(1));
  assign ret_last      = acc && ret_end_sweep && (ret_sweep == sweeps_q - SWEEP_BITS'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok) state_nx = S_RUN;
      S_RUN:   if (iss_last) state_nx = S_DRAIN;
      S_DRAIN: if (ret_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy                = active;
    done                = (state == S_DONE);
    buf_data_tready     = active ? out_tready : 1'b0;
    out_tlast           = active && buf_data_tvalid && ret_end_sweep;
    out_sweep           = ret_sweep;
    m_axis_index_tvalid = tvalid_q;
    m_axis_index_tdata  = iss_addr;
  end

  always_comb begin
    outstanding_nx = outstanding;
    if (hs && !acc)      outstanding_nx = outstanding + 4'd1;
    else if (!hs && acc) outstanding_nx = outstanding - 4'd1;
  end

  // tvalid is registered, so it looks one cycle ahead at the outstanding count;
  // once raised it is held until the handshake.
  always_comb begin
    tvalid_nx = 1'b0;
    case (state)
      S_IDLE: tvalid_nx = start_ok;
      S_RUN: begin
        if (iss_last)              tvalid_nx = 1'b0;
        else if (tvalid_q && !hs)  tvalid_nx = 1'b1;
        else                       tvalid_nx = (outstanding_nx < MAX_OUT);
      end
      default: tvalid_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q       <= '0;
      sweeps_q    <= '0;
      stride_q    <= '0;
      sweep_base  <= '0;
      iss_addr    <= '0;
      iss_cnt     <= '0;
      iss_sweep   <= '0;
      ret_cnt     <= '0;
      ret_sweep   <= '0;
      outstanding <= '0;
      tvalid_q    <= 1'b0;
    end else begin
      tvalid_q <= tvalid_nx;
      if (state == S_IDLE && start_ok) begin
        len_q       <= cfg_len;
        sweeps_q    <= cfg_sweeps;
        stride_q    <= cfg_stride;
        sweep_base  <= cfg_base;
        iss_addr    <= cfg_base;
        iss_cnt     <= '0;
        iss_sweep   <= '0;
        ret_cnt     <= '0;
        ret_sweep   <= '0;
        outstanding <= '0;
      end else begin
        outstanding <= outstanding_nx;
        if (hs) begin
          if (iss_end_sweep) begin
            iss_cnt    <= '0;
            iss_sweep  <= iss_sweep + SWEEP_BITS'(1);
            sweep_base <= sweep_base + stride_q;
            iss_addr   <= sweep_base + stride_q;
          end else begin
            iss_cnt  <= iss_cnt + LEN_BITS'(1);
            iss_addr <= iss_addr + BUFFER_BITS'(1);
          end
        end
        if (acc) begin
          if (ret_end_sweep) begin
            ret_cnt   <= '0;
            ret_sweep <= ret_sweep + SWEEP_BITS'(1);
          end else begin
            ret_cnt <= ret_cnt + LEN_BITS'(1);
          end
        end
      end
    end
  end

endmodule
